// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the BRAM data-port arbiter.
//   state_e          : arbiter FSM states
//   ROM_BASE         : first address of the read-only upper half
//   READ_LATENCY_DEF : default cycles an address is held before read data is valid
//   WR_TIMEOUT_DEF   : default cycles after a write issue before it is declared lost
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StWrSetup,
    StWrIssue,
    StWrWait,
    StDone
  } state_e;

  localparam logic [15:0] ROM_BASE = 16'h8000;

  localparam int unsigned READ_LATENCY_DEF = 2;
  localparam int unsigned WR_TIMEOUT_DEF   = 8;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
//   req  in  2  request vector, bit n = port n
//   last in  1  index of the port that won the previous arbitration
//   gnt  out 2  one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Conflict: the port that did not win last time goes first.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_data_arbiter.sv
// Shares the byte-wide BRAM data port between port 0 (CPU LSU) and port 1 (loader/debug).
// One transaction outstanding at a time, round-robin on conflict. Reads hold the address
// for READ_LATENCY cycles before sampling; writes hold it for READ_LATENCY cycles (merge
// word), issue a one-cycle req/write strobe and wait for mem_data_done with a timeout.
// Writes to the upper half (>= ROM_BASE) are rejected without touching memory.
//   clock, reset_n           : clock, async active-low reset
//   req/write/addr/wdata 0,1 : requester side; fields latched at gnt
//   gnt, done, rdata, err 0,1: one-cycle grant, one-cycle completion, read byte, error flag
//   mem_data_*               : memory data port
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF,
  parameter int unsigned WR_TIMEOUT   = WR_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        write0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  input  logic        req1,
  input  logic        write1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] mem_data_addr,
  output logic [7:0]  mem_data_in,
  output logic        mem_data_write,
  output logic        mem_data_req,
  input  logic        mem_data_done,
  input  logic [7:0]  mem_data_out
);

  localparam int unsigned CntMax = max2(READ_LATENCY, WR_TIMEOUT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic              err_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata0_q;
  logic [7:0]        rdata1_q;
  logic [CntW-1:0]   cnt_q;

  logic [1:0]        arb_req;
  logic [1:0]        pick;
  logic              sel_write;
  logic [15:0]       sel_addr;
  logic [7:0]        sel_wdata;

  // Grants only in IDLE; reset_n gating keeps gnt low while reset is held.
  assign arb_req = (state_q == StIdle && reset_n) ? {req1, req0} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req  (arb_req),
    .last (last_q),
    .gnt  (pick)
  );

  assign sel_write = pick[1] ? write1 : write0;
  assign sel_addr  = pick[1] ? addr1  : addr0;
  assign sel_wdata = pick[1] ? wdata1 : wdata0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|pick) begin
            owner_q <= pick[1];
            last_q  <= pick[1];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            if (!sel_write) begin
              state_q <= StRdWait;
            end else if (sel_addr >= ROM_BASE) begin
              state_q <= StDone;
              err_q   <= 1'b1;
            end else begin
              state_q <= StWrSetup;
            end
          end
        end
        StRdWait: begin
          if (cnt_q == CntW'(READ_LATENCY - 1)) begin
            if (owner_q) rdata1_q <= mem_data_out;
            else         rdata0_q <= mem_data_out;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrSetup: begin
          if (cnt_q == CntW'(READ_LATENCY - 1)) begin
            state_q <= StWrIssue;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrIssue: begin
          cnt_q   <= '0;
          state_q <= StWrWait;
        end
        StWrWait: begin
          // Last wait cycle is WR_TIMEOUT-1 after the issue, so DONE lands exactly
          // WR_TIMEOUT cycles after it. A done in that last cycle still counts.
          if (mem_data_done) begin
            err_q   <= 1'b0;
            state_q <= StDone;
          end else if (cnt_q == CntW'(WR_TIMEOUT - 2)) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt0           = pick[0];
  assign gnt1           = pick[1];
  assign done0          = (state_q == StDone) && !owner_q;
  assign done1          = (state_q == StDone) && owner_q;
  assign err0           = done0 && err_q;
  assign err1           = done1 && err_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_data_addr  = addr_q;
  assign mem_data_in    = wdata_q;
  assign mem_data_req   = (state_q == StWrIssue);
  assign mem_data_write = (state_q == StWrIssue);

endmodule

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Shares the single byte-wide data port of the on-chip block-RAM memory between two requesters: port 0 is the CPU load/store unit and port 1 is the program loader/debug master. It arbitrates round-robin and holds one transaction outstanding at a time. It also sequences the memory's timing: it holds the address stable through the BRAM read latency before sampling read data or issuing a read-modify-write. Writes to the read-only upper half are rejected locally, and a lost write-done is caught by a timeout.

## Interface
- READ_LATENCY, 2: cycles an address must be held before mem_data_out is valid; must be ≥1.
- WR_TIMEOUT, 8: cycles after the write issue without mem_data_done before the write fails; must be ≥2.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request; held until gnt of that port.
- write0 / write1  in  1  1 = byte write, 0 = byte read.
- addr0 / addr1  in  16  byte address.
- wdata0 / wdata1  in  8  write data.
- gnt0 / gnt1  out  1  one-cycle pulse; the request is accepted and its fields are latched.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  8  read byte; valid with done and held until the next done on that port.
- err0 / err1  out  1  valid with done; 1 = write rejected or timed out.
- mem_data_addr  out  16  to the memory data_addr.
- mem_data_in  out  8  to the memory data_in.
- mem_data_write  out  1  to the memory data_write.
- mem_data_req  out  1  to the memory data_req.
- mem_data_done  in  1  from the memory data_done.
- mem_data_out  in  8  from the memory data_out.

## Operation
- States: IDLE, RD_WAIT, WR_SETUP, WR_ISSUE, WR_WAIT, DONE.
- IDLE: if any req is high, pick a winner, pulse its gnt, and latch owner, addr, wdata and write.
  - On conflict the winner is the port that did not win last.
  - The last-winner pointer resets to port 1, so port 0 wins the first conflict.
  - Next state:
    - read → RD_WAIT;
    - write with addr[15]=0 → WR_SETUP;
    - write with addr[15]=1 → DONE with err=1, no memory access.
- RD_WAIT: hold mem_data_addr for READ_LATENCY cycles, sample mem_data_out into the owner's rdata on the last cycle, then → DONE with err=0.
- WR_SETUP: hold the address for READ_LATENCY cycles so the memory's merge word is valid, then → WR_ISSUE.
- WR_ISSUE: mem_data_req=1 and mem_data_write=1 for exactly one cycle, then → WR_WAIT.
- WR_WAIT: on mem_data_done → DONE with err=0. If WR_TIMEOUT cycles pass after WR_ISSUE without it → DONE with err=1.
- DONE: pulse the owner's done and err for one cycle, then → IDLE. No grant is made in DONE.
- mem_data_addr and mem_data_in always show the latched fields. mem_data_req and mem_data_write are 0 outside WR_ISSUE.
- Request fields are ignored after gnt; a requester may change or drop them freely.

## Timing
- Let G be the gnt cycle.
- Read: done at G+READ_LATENCY+1; next gnt at earliest G+READ_LATENCY+2.
- Write: WR_ISSUE at G+READ_LATENCY+1; mem_data_done expected at G+READ_LATENCY+2; done at G+READ_LATENCY+3.
- Rejected write (addr[15]=1): done with err=1 at G+1.
- A req that appears in a non-IDLE state waits; it is never dropped.
- Both ports requesting continuously strictly alternate.
- Reset values: all gnt, done, err, rdata = 0; mem_* outputs = 0; state IDLE; pointer = port 1.
- Asserting reset_n low mid-transaction aborts immediately: no done is pulsed, and an unissued write never reaches memory.

## Structure
- Package mem_arb_pkg holds:
  - the state enum;
  - ROM_BASE = 16'h8000;
  - the default READ_LATENCY and WR_TIMEOUT.
- Sub-module rr_arb2: a combinational two-way round-robin picker (inputs req[1:0] and the last winner; outputs a one-hot grant). The pointer register stays in mem_data_arbiter.
- The latency and timeout counters share one counter whose width is derived from max(READ_LATENCY, WR_TIMEOUT).

## Test plan
- Port 0 reads 0x0010, memory model returns 0xA5 after 2 cycles → gnt0 at G, done0 at G+3, rdata0=0xA5, err0=0, mem_data_req never high.
- Port 1 writes 0x5A to 0x0101 → one-cycle mem_data_req/mem_data_write at G+3 with addr 0x0101 and data 0x5A; done1 at G+5, err1=0; a read-back returns 0x5A.
- Port 0 writes 0x7FFF→0x8000 boundary: a write to 0x8000 → done0 at G+1 with err0=1 and no mem_data_req; a write to 0x7FFF succeeds.
- Both req held high for 6 transactions → grants in order 0,1,0,1,0,1 with no transaction lost.
- Memory model suppresses mem_data_done → done with err=1 exactly WR_TIMEOUT cycles after the issue cycle; the next request is served normally.
- Drop reset_n during RD_WAIT and during WR_SETUP → all outputs 0 at once, no done, no mem_data_req. After release, a request from port 0 is granted.
